// File: rtl/tx_seq_pkg.sv
// Shared state type and counter-width helpers for the transmit byte sequencer.
package tx_seq_pkg;

   typedef enum logic {IDLE, ACTIVE} tx_seq_state_t;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned clk_cnt_width(input int unsigned clks_per_bit);
      return cnt_width(clks_per_bit);
   endfunction

   function automatic int unsigned bit_cnt_width(input int unsigned num_bits);
      return cnt_width(num_bits);
   endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while running, flags the final clock
// of each bit period now (bit_tick) and one clock ahead (tick_next).
module tx_bit_timer
   import tx_seq_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 8
)(
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic bit_tick,
   output logic tick_next
);

   localparam int unsigned CW = clk_cnt_width(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] clk_cnt;
   logic [CW-1:0] clk_cnt_n;

   always_comb begin
      clk_cnt_n = clk_cnt;
      if (clear)
         clk_cnt_n = '0;
      else if (run)
         clk_cnt_n = (clk_cnt == LAST_CLK) ? '0 : clk_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         clk_cnt <= '0;
      else
         clk_cnt <= clk_cnt_n;
   end

   assign bit_tick  = (clk_cnt == LAST_CLK);
   // Lets the sequencer register its strobes so they land in the tick cycle itself.
   assign tick_next = (clk_cnt_n == LAST_CLK);

endmodule

// File: rtl/tx_byte_sequencer.sv
// Drives load/shift strobes of the transmit shift register from a valid/ready byte
// stream with one-byte hold buffering. Define TX_SEQ_BYTE_CNT_EN for the byte_count output.
module tx_byte_sequencer
   import tx_seq_pkg::*;
#(
   parameter int unsigned NUM_BITS     = 8,
   parameter int unsigned CLKS_PER_BIT = 8
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_BITS-1:0] tx_data,
   input  logic                tx_valid,
   input  logic                tx_last,
   output logic                tx_ready,
   output logic                load_enable,
   output logic                shift_enable,
   output logic [NUM_BITS-1:0] parallel_in,
   output logic                busy,
   output logic                eop,
   output logic                underrun
`ifdef TX_SEQ_BYTE_CNT_EN
   ,
   output logic [15:0]         byte_count
`endif
);

   localparam int unsigned BW = bit_cnt_width(NUM_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);

   tx_seq_state_t       state;
   tx_seq_state_t       state_n;
   logic [NUM_BITS-1:0] hold_data;
   logic                hold_valid;
   logic                hold_valid_n;
   logic                hold_last;
   logic                cur_last;
   logic                cur_last_n;
   logic [BW-1:0]       bit_cnt;
   logic [BW-1:0]       bit_cnt_n;
   logic                accept;
   logic                bit_tick;
   logic                tick_next;
   logic                dry;

   assign accept      = tx_valid && tx_ready;
   assign dry         = (state == ACTIVE) && bit_tick && (bit_cnt == LAST_BIT) &&
                        !cur_last && !hold_valid;
   assign busy        = (state == ACTIVE);
   assign parallel_in = hold_data;

   tx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .run      (state == ACTIVE),
      .clear    (load_enable),
      .bit_tick (bit_tick),
      .tick_next(tick_next)
   );

   // Strobes are registered, so they describe the current cycle and drive the
   // next-state decode directly; their own next values come from the *_n terms.
   always_comb begin
      hold_valid_n = hold_valid;
      if (accept)
         hold_valid_n = 1'b1;
      else if (load_enable)
         hold_valid_n = 1'b0;

      cur_last_n = load_enable ? hold_last : cur_last;

      bit_cnt_n = bit_cnt;
      if (load_enable)
         bit_cnt_n = '0;
      else if (shift_enable)
         bit_cnt_n = bit_cnt + 1'b1;

      state_n = state;
      if (load_enable)
         state_n = ACTIVE;
      else if (eop || dry)
         state_n = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         hold_data    <= '0;
         hold_valid   <= 1'b0;
         hold_last    <= 1'b0;
         cur_last     <= 1'b0;
         bit_cnt      <= '0;
         tx_ready     <= 1'b1;
         load_enable  <= 1'b0;
         shift_enable <= 1'b0;
         eop          <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         state      <= state_n;
         hold_valid <= hold_valid_n;
         cur_last   <= cur_last_n;
         bit_cnt    <= bit_cnt_n;
         if (accept) begin
            hold_data <= tx_data;
            hold_last <= tx_last;
         end
         tx_ready     <= !hold_valid_n;
         load_enable  <= hold_valid_n &&
                         ((state_n == IDLE) ||
                          (tick_next && (bit_cnt_n == LAST_BIT) && !cur_last_n));
         shift_enable <= (state_n == ACTIVE) && tick_next && (bit_cnt_n < LAST_BIT);
         eop          <= (state_n == ACTIVE) && tick_next && (bit_cnt_n == LAST_BIT) &&
                         cur_last_n;
         if (dry)
            underrun <= 1'b1;
      end
   end

`ifdef TX_SEQ_BYTE_CNT_EN
   always_ff @(posedge clk) begin
      if (rst || eop)
         byte_count <= '0;
      else if (load_enable && (byte_count != '1))
         byte_count <= byte_count + 1'b1;
   end
`endif

endmodule

// File: tb/tb_tx_byte_sequencer.sv
// Directed bench for tx_byte_sequencer (NUM_BITS=8, CLKS_PER_BIT=8); byte counter
// checks are included when TX_SEQ_BYTE_CNT_EN is defined.
module tb_tx_byte_sequencer;

   localparam int unsigned NB  = 8;
   localparam int unsigned CPB = 8;
   localparam int BYTE_CLKS    = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic       load_enable;
   logic       shift_enable;
   logic [7:0] parallel_in;
   logic       busy;
   logic       eop;
   logic       underrun;
`ifdef TX_SEQ_BYTE_CNT_EN
   logic [15:0] byte_count;
   logic [15:0] bc_at_eop;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int clash    = 0;
   int load_cyc[$];
   logic [7:0] load_dat[$];
   int shift_cyc[$];
   int eop_cyc[$];
   logic [7:0] bp_bytes [4] = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};

   tx_byte_sequencer #(
      .NUM_BITS    (NB),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_last     (tx_last),
      .tx_ready    (tx_ready),
      .load_enable (load_enable),
      .shift_enable(shift_enable),
      .parallel_in (parallel_in),
      .busy        (busy),
      .eop         (eop),
      .underrun    (underrun)
`ifdef TX_SEQ_BYTE_CNT_EN
      ,
      .byte_count  (byte_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event log taken mid-cycle; cyc identifies the cycle following the cyc-th rising edge.
   always @(negedge clk) begin
      if (load_enable) begin
         load_cyc.push_back(cyc);
         load_dat.push_back(parallel_in);
      end
      if (shift_enable) shift_cyc.push_back(cyc);
      if (eop) eop_cyc.push_back(cyc);
      if (load_enable && shift_enable) clash <= clash + 1;
`ifdef TX_SEQ_BYTE_CNT_EN
      if (eop) bc_at_eop <= byte_count;
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      load_cyc.delete();
      load_dat.delete();
      shift_cyc.delete();
      eop_cyc.delete();
   endtask

   // Offers one byte and returns the cycle in which the handshake happened; leaves tx_valid high.
   task automatic send(input logic [7:0] d, input logic l, input string tag, output int acc);
      int  k;
      logic got;
      k   = 0;
      got = 1'b0;
      tx_data  = d;
      tx_last  = l;
      tx_valid = 1'b1;
      while (!got && k < 200) begin
         got = tx_ready;
         tick();
         k++;
      end
      chk({tag, "_accept"}, got, 1'b1);
      acc = cyc - 1;
   endtask

   task automatic wait_eops(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (eop_cyc.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk(tag, eop_cyc.size() >= n, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc;
      int la;
      int k;
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      tx_data  = 8'h00;
      repeat (3) tick();

      chk("rst_tx_ready", tx_ready, 1'b1);
      chk("rst_load", load_enable, 1'b0);
      chk("rst_shift", shift_enable, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_eop", eop, 1'b0);
      chk("rst_underrun", underrun, 1'b0);
      chk("rst_parallel_in", parallel_in, 8'h00);
      rst = 1'b0;
      repeat (2) tick();

      // Single byte with tx_last
      clear_logs();
      send(8'hA5, 1'b1, "single", acc);
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      wait_eops(1, 120, "single_eop_seen");
      la = load_cyc[0];
      chk("single_busy_after_eop", busy, 1'b0);
      chk("single_eop_one_cycle", eop, 1'b0);
      chk("single_load_count", load_cyc.size(), 1);
      chk("single_load_latency", la, acc + 1);
      chk("single_load_data", load_dat[0], 8'hA5);
      chk("single_shift_count", shift_cyc.size(), 7);
      for (int i = 0; i < 7; i++)
         chk("single_shift_spacing", shift_cyc[i], la + 8 * (i + 1));
      chk("single_eop_cycle", eop_cyc[0], la + BYTE_CLKS);
      chk("single_tx_ready", tx_ready, 1'b1);
      chk("single_underrun", underrun, 1'b0);
      repeat (5) tick();
      chk("single_no_idle_load", load_cyc.size(), 1);

      // Back-to-back three-byte packet
      clear_logs();
      send(8'h11, 1'b0, "b2b0", acc);
      send(8'h22, 1'b0, "b2b1", acc);
      send(8'h33, 1'b1, "b2b2", acc);
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      wait_eops(1, 300, "b2b_eop_seen");
      repeat (5) tick();
      chk("b2b_load_count", load_cyc.size(), 3);
      chk("b2b_data0", load_dat[0], 8'h11);
      chk("b2b_data1", load_dat[1], 8'h22);
      chk("b2b_data2", load_dat[2], 8'h33);
      chk("b2b_gap01", load_cyc[1] - load_cyc[0], BYTE_CLKS);
      chk("b2b_gap12", load_cyc[2] - load_cyc[1], BYTE_CLKS);
      chk("b2b_eop_count", eop_cyc.size(), 1);
      chk("b2b_eop_cycle", eop_cyc[0], load_cyc[2] + BYTE_CLKS);
      chk("b2b_shift_count", shift_cyc.size(), 21);
      chk("b2b_underrun", underrun, 1'b0);
      chk("b2b_busy_end", busy, 1'b0);

      // Backpressure: tx_valid stays high across four bytes
      clear_logs();
      for (int i = 0; i < 4; i++) begin
         send(bp_bytes[i], (i == 3), "bp", acc);
         chk("bp_ready_low_when_held", tx_ready, 1'b0);
      end
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      wait_eops(1, 400, "bp_eop_seen");
      chk("bp_load_count", load_cyc.size(), 4);
      for (int i = 0; i < 4; i++)
         chk("bp_data_order", load_dat[i], bp_bytes[i]);
      chk("bp_eop_count", eop_cyc.size(), 1);
      chk("bp_underrun", underrun, 1'b0);

      // Underrun: non-last byte with nothing behind it
      clear_logs();
      send(8'h44, 1'b0, "ur", acc);
      tx_valid = 1'b0;
      k = 0;
      while (!underrun && k < 150) begin
         tick();
         k++;
      end
      chk("ur_seen", underrun, 1'b1);
      chk("ur_cycle", cyc, load_cyc[0] + BYTE_CLKS + 1);
      chk("ur_busy", busy, 1'b0);
      chk("ur_tx_ready", tx_ready, 1'b1);
      chk("ur_no_eop", eop_cyc.size(), 0);
      repeat (10) tick();
      chk("ur_sticky", underrun, 1'b1);

      // Reset twenty clocks into a byte
      clear_logs();
      send(8'h96, 1'b1, "mid", acc);
      tx_valid = 1'b0;
      repeat (20) tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_load", load_enable, 1'b0);
      chk("mid_rst_shift", shift_enable, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_eop", eop, 1'b0);
      chk("mid_rst_underrun", underrun, 1'b0);
      chk("mid_rst_parallel_in", parallel_in, 8'h00);
      chk("mid_rst_tx_ready", tx_ready, 1'b1);
      rst = 1'b0;
      tick();
      clear_logs();
      send(8'h3C, 1'b1, "post", acc);
      tx_valid = 1'b0;
      wait_eops(1, 120, "post_eop_seen");
      chk("post_load_count", load_cyc.size(), 1);
      chk("post_load_latency", load_cyc[0], acc + 1);
      chk("post_load_data", load_dat[0], 8'h3C);
      chk("post_shift_count", shift_cyc.size(), 7);
      chk("post_eop_cycle", eop_cyc[0], load_cyc[0] + BYTE_CLKS);

`ifdef TX_SEQ_BYTE_CNT_EN
      // Five-byte packet for the byte counter
      clear_logs();
      for (int i = 0; i < 5; i++)
         send(8'h80 + 8'(i), (i == 4), "bc", acc);
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      wait_eops(1, 500, "bc_eop_seen");
      chk("bc_at_eop", bc_at_eop, 16'd5);
      chk("bc_cleared", byte_count, 16'd0);
`endif

      chk("strobe_clash", clash, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
